mips_bus_ctrl: RTL

- Multi-cycle bus sequencer for the MIPS231 core, allowing the single-cycle datapath/controller to run against variable-latency instruction and data memories.
- Fetches each instruction over a req/ack port and latches it. For lw/sw it performs the data access over a second req/ack port, then asserts the core's enable for exactly one cycle to commit state.
- Sits between the core top level and the memory system. Adds wait-state tolerance, an access timeout fault and a retired-instruction counter.

---
 rtl/mips_bus_pkg.sv | 20 ++
 rtl/mips_bus_timer.sv | 44 ++++
 rtl/mips_bus_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and opcode constants for the MIPS231 multi-cycle bus sequencer.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM,
    COMMIT,
    FAULT
  } bus_state_t;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_bus_timer.sv
// Per-access wait counter: clears while no access is outstanding, counts un-acked
// cycles, and flags expiry on the cycle that would bring the count up to TIMEOUT.
module mips_bus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic srst,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt_reg;
  logic [CW-1:0] wait_cnt_next;

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!active) begin
      wait_cnt_next = '0;
    end else if (!ack) begin
      wait_cnt_next = wait_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expire = 1'b0;
    end else begin : g_timeout
      // Expiry is raised on the last permitted wait cycle so the FSM leaves on that edge.
      assign expire = active && !ack && (wait_cnt_reg == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mips_bus_ctrl.sv
// Multi-cycle bus sequencer: fetches over imem, performs lw/sw over dmem, then
// pulses core_enable for one cycle to commit the single-cycle core's state.
module mips_bus_ctrl
  import mips_bus_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [31:0]     core_pc,
  input  logic [31:0]     core_mem_addr,
  input  logic [DW-1:0]   core_mem_writedata,
  output logic [DW-1:0]   core_instr,
  output logic [DW-1:0]   core_mem_readdata,
  output logic            core_enable,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [DW-1:0]   imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [DW-1:0]   dmem_wdata,
  input  logic            dmem_ack,
  input  logic [DW-1:0]   dmem_rdata,
  output logic            busy,
  output logic            fault,
  output logic [CNTW-1:0] retired
);

  bus_state_t      state_reg;
  bus_state_t      state_next;
  logic [DW-1:0]   core_instr_reg;
  logic [DW-1:0]   readdata_reg;
  logic [CNTW-1:0] retired_reg;

  logic [5:0] opcode;
  logic       is_lw;
  logic       is_sw;
  logic       timer_active;
  logic       timer_ack;
  logic       timer_expire;

  assign opcode = core_instr_reg[31:26];
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);

  // Only one port is ever requested at a time, so a single counter serves both.
  assign timer_active = (state_reg == FETCH) || (state_reg == MEM);
  assign timer_ack    = (state_reg == FETCH) ? imem_ack : dmem_ack;

  mips_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .srst  (reset),
    .active(timer_active),
    .ack   (timer_ack),
    .expire(timer_expire)
  );

  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    core_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)          state_next = DECODE;
        else if (timer_expire) state_next = FAULT;
      end
      DECODE: begin
        state_next = is_mem_op(opcode) ? MEM : COMMIT;
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack)          state_next = COMMIT;
        else if (timer_expire) state_next = FAULT;
      end
      COMMIT: begin
        core_enable = 1'b1;
        state_next  = run ? FETCH : IDLE;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address/data outputs follow the core directly; the core holds them steady
  // because core_enable stays low until the access completes.
  assign imem_addr  = imem_req ? core_pc[AW-1:0] : '0;
  assign dmem_we    = dmem_req && is_sw;
  assign dmem_addr  = dmem_req ? core_mem_addr[AW-1:0] : '0;
  assign dmem_wdata = dmem_req ? core_mem_writedata : '0;

  assign busy              = (state_reg != IDLE) && (state_reg != FAULT);
  assign fault             = (state_reg == FAULT);
  assign core_instr        = core_instr_reg;
  assign core_mem_readdata = readdata_reg;
  assign retired           = retired_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      core_instr_reg <= '0;
      readdata_reg   <= '0;
      retired_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == FETCH) && imem_ack) begin
        core_instr_reg <= imem_rdata;
      end
      if ((state_reg == MEM) && dmem_ack && is_lw) begin
        readdata_reg <= dmem_rdata;
      end
      if (state_reg == COMMIT) begin
        retired_reg <= retired_reg + CNTW'(1);
      end
    end
  end

endmodule
